// File: rtl/sprite_render_if.sv
// Pixel-stream / sprite-ROM / mixer-output bundle for sprite_render.
// The slave modport is the render engine; the master modport is the scan source, ROM and mixer side.
interface sprite_render_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 13,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 9
);
  logic              pix_valid;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic              out_hit;
  logic [DATA_W-1:0] out_data;

  modport master (output pix_valid, col, row, mem_data,
                  input  mem_addr, out_valid, out_hit, out_data);
  modport slave  (input  pix_valid, col, row, mem_data,
                  output mem_addr, out_valid, out_hit, out_data);
endinterface

// File: rtl/sprite_render.sv
// Raster-order sprite fetch engine with integer X/Y scaling and a fixed 3-cycle pipeline.
// Optional colour keying is enabled by defining SPRITE_KEY_EN.
module sprite_render #(
  parameter int               DATA_W  = 12,
  parameter int               ADDR_W  = 13,
  parameter int               COL_W   = 10,
  parameter int               ROW_W   = 9,
  parameter int               SCALE_W = 4,
  parameter logic [DATA_W-1:0] KEY    = 12'h000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               en,
  input  logic [COL_W-1:0]   posx,
  input  logic [ROW_W-1:0]   posy,
  input  logic [COL_W-1:0]   width,
  input  logic [ROW_W-1:0]   height,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [SCALE_W-1:0] scale_x,
  input  logic [SCALE_W-1:0] scale_y,
  sprite_render_if.slave     bus
);
  localparam int STAGES = 3;

  typedef enum logic [2:0] {IDLE, WAIT, ACTIVE, GAP, DONE} state_t;

  typedef struct packed {
    logic               en;
    logic [COL_W-1:0]   posx;
    logic [ROW_W-1:0]   posy;
    logic [COL_W-1:0]   width;
    logic [ROW_W-1:0]   height;
    logic [ADDR_W-1:0]  base;
    logic [SCALE_W-1:0] sx_last;
    logic [SCALE_W-1:0] sy_last;
  } cfg_t;

  cfg_t               cfg_q;
  state_t             state_q, state_d;
  logic [COL_W-1:0]   src_x_q, src_x_d, cur_x;
  logic [ROW_W-1:0]   src_y_q, src_y_d;
  logic [SCALE_W-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d, cur_sub;
  logic [ADDR_W-1:0]  line_base_q, line_base_d, draw_base;
  logic               draw, start_line;

  logic [STAGES-1:0]  vld_pipe;
  logic [1:0]         hit_pipe;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               out_hit_q, texel_hit;
  logic [DATA_W-1:0]  out_data_q;

  always_comb begin
    state_d     = state_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    sub_x_d     = sub_x_q;
    sub_y_d     = sub_y_q;
    line_base_d = line_base_q;
    start_line  = 1'b0;
    draw        = 1'b0;
    if (frame_start) begin
      state_d = en ? WAIT : IDLE;
    end else if (bus.pix_valid) begin
      unique case (state_q)
        WAIT: if (bus.row == cfg_q.posy && bus.col == cfg_q.posx) begin
          if (cfg_q.width == '0 || cfg_q.height == '0) begin
            state_d = DONE;
          end else begin
            start_line  = 1'b1;
            src_y_d     = '0;
            sub_y_d     = '0;
            line_base_d = cfg_q.base;
          end
        end
        ACTIVE: draw = 1'b1;
        // Only reachable again on the following row, since this row drew from posx rightwards.
        GAP: if (bus.col == cfg_q.posx) begin
          if (sub_y_q == cfg_q.sy_last) begin
            sub_y_d = '0;
            if (src_y_q == cfg_q.height - 1'b1) begin
              state_d = DONE;
            end else begin
              start_line  = 1'b1;
              src_y_d     = src_y_q + 1'b1;
              line_base_d = line_base_q + ADDR_W'(cfg_q.width);
            end
          end else begin
            start_line = 1'b1;
            sub_y_d    = sub_y_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (start_line) draw = 1'b1;
    cur_x     = start_line ? '0 : src_x_q;
    cur_sub   = start_line ? '0 : sub_x_q;
    draw_base = line_base_d;
    if (draw) begin
      state_d = ACTIVE;
      src_x_d = cur_x;
      if (cur_sub == cfg_q.sx_last) begin
        sub_x_d = '0;
        if (cur_x == cfg_q.width - 1'b1) state_d = GAP;
        else                             src_x_d = cur_x + 1'b1;
      end else begin
        sub_x_d = cur_sub + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      sub_x_q     <= '0;
      sub_y_q     <= '0;
      line_base_q <= '0;
    end else begin
      state_q     <= state_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      sub_x_q     <= sub_x_d;
      sub_y_q     <= sub_y_d;
      line_base_q <= line_base_d;
      if (frame_start) begin
        cfg_q.en      <= en;
        cfg_q.posx    <= posx;
        cfg_q.posy    <= posy;
        cfg_q.width   <= width;
        cfg_q.height  <= height;
        cfg_q.base    <= base_addr;
        cfg_q.sx_last <= (scale_x == '0) ? '0 : scale_x - 1'b1;
        cfg_q.sy_last <= (scale_y == '0) ? '0 : scale_y - 1'b1;
      end
    end
  end

`ifdef SPRITE_KEY_EN
  assign texel_hit = hit_pipe[1] && (bus.mem_data != KEY);
`else
  logic unused_key;
  assign unused_key = ^KEY;
  assign texel_hit  = hit_pipe[1];
`endif

  // C1 issues the ROM address, C2 waits on the ROM, C3 merges colour and hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      hit_pipe   <= '0;
      mem_addr_q <= '0;
      out_hit_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], bus.pix_valid};
      hit_pipe <= {hit_pipe[0], draw};
      if (draw) mem_addr_q <= draw_base + ADDR_W'(cur_x);
      if (vld_pipe[1]) begin
        out_hit_q  <= texel_hit;
        out_data_q <= texel_hit ? bus.mem_data : '0;
      end
    end
  end

  assign bus.out_valid = vld_pipe[STAGES-1];
  assign bus.out_hit   = out_hit_q;
  assign bus.out_data  = out_data_q;
  assign bus.mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_sprite_render.sv
// Scoreboard bench for sprite_render: a geometric reference model predicts every pixel result.
module tb_sprite_render;
  localparam int DATA_W = 12, ADDR_W = 13, COL_W = 10, ROW_W = 9, SCALE_W = 4;
  localparam int SCR_W = 24, SCR_H = 12;

  logic clk = 1'b0, rst, frame_start, en;
  logic [COL_W-1:0]   posx, width;
  logic [ROW_W-1:0]   posy, height;
  logic [ADDR_W-1:0]  base_addr;
  logic [SCALE_W-1:0] scale_x, scale_y;

  sprite_render_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COL_W(COL_W), .ROW_W(ROW_W)) bus();

  sprite_render dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .en(en),
    .posx(posx), .posy(posy), .width(width), .height(height),
    .base_addr(base_addr), .scale_x(scale_x), .scale_y(scale_y), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    int posx, posy, width, height, base, sx, sy;
    int exp_hits;
  } vec_t;

  typedef struct {
    logic hit;
    logic [DATA_W-1:0] data;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t lat;
  int   n_chk = 0, n_fail = 0, cyc = 0, hit_cnt = 0;
  logic mon_en = 1'b0;

  function automatic logic [DATA_W-1:0] rom_f(int a);
    logic [DATA_W-1:0] h;
    if (a == 300) return 12'h000;
    if (a == 301) return 12'hF00;
    h = DATA_W'((a * 29 + 7) ^ (a >> 2));
    return {h[DATA_W-1:1], 1'b1};
  endfunction

  always @(posedge clk) bus.mem_data <= rom_f(int'(bus.mem_addr));
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int c, input int r, output logic hit, output logic [DATA_W-1:0] d);
    int sx, sy, a;
    sx  = (lat.sx == 0) ? 1 : lat.sx;
    sy  = (lat.sy == 0) ? 1 : lat.sy;
    hit = lat.en && lat.width > 0 && lat.height > 0 &&
          c >= lat.posx && c < lat.posx + lat.width * sx &&
          r >= lat.posy && r < lat.posy + lat.height * sy;
    d = '0;
    if (hit) begin
      a = (lat.base + ((r - lat.posy) / sy) * lat.width + (c - lat.posx) / sx) % (1 << ADDR_W);
      d = rom_f(a);
`ifdef SPRITE_KEY_EN
      if (d == 12'h000) hit = 1'b0;
`endif
      if (!hit) d = '0;
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en && bus.out_valid) begin
      if (sbq.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        check("latency", cyc - e.cyc, 32'd3);
        check("out_hit", {31'd0, bus.out_hit}, {31'd0, e.hit});
        check("out_data", {20'd0, bus.out_data}, {20'd0, e.data});
        if (bus.out_hit) hit_cnt++;
      end
    end
  end

  task automatic apply_cfg(input vec_t v);
    en = v.en; posx = COL_W'(v.posx); posy = ROW_W'(v.posy);
    width = COL_W'(v.width); height = ROW_W'(v.height);
    base_addr = ADDR_W'(v.base); scale_x = SCALE_W'(v.sx); scale_y = SCALE_W'(v.sy);
  endtask

  task automatic start_frame(input vec_t v);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    apply_cfg(v);
    frame_start = 1'b1;
    lat = v;
    hit_cnt = 0;
  endtask

  task automatic pix(input int c, input int r);
    exp_t e;
    @(negedge clk);
    frame_start = 1'b0;
    bus.pix_valid = 1'b1;
    bus.col = COL_W'(c);
    bus.row = ROW_W'(r);
    model(c, r, e.hit, e.data);
    e.cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_start = 1'b0;
      bus.pix_valid = 1'b0;
    end
  endtask

  // Scans pixels from index 'from'; inputs switch to v2 at index chg_at (if >= 0).
  task automatic scan(input int from, input int chg_at, input vec_t v2);
    for (int i = from; i < SCR_W * SCR_H; i++) begin
      pix(i % SCR_W, i / SCR_W);
      if (i == chg_at) apply_cfg(v2);
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    idle(1);
  endtask

  task automatic drain(input string name, input int exp_hits);
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
    idle(2);
    check({name, "_drain"}, sbq.size(), 32'd0);
    check({name, "_hits"}, hit_cnt, exp_hits);
  endtask

  vec_t vecs[10];
  vec_t va, vb;

  initial begin
`ifdef SPRITE_KEY_EN
    int key_hits = 1;
`else
    int key_hits = 2;
`endif
    //         en posx posy w  h  base  sx sy hits
    vecs[0] = '{1'b1, 10,  5, 4, 2,  100, 1, 1, 8};
    vecs[1] = '{1'b1,  0,  0, 2, 2,  200, 3, 2, 24};
    vecs[2] = '{1'b0,  2,  2, 3, 3,  100, 1, 1, 0};
    vecs[3] = '{1'b1,  2,  2, 0, 3,  100, 1, 1, 0};
    vecs[4] = '{1'b1,  3,  1, 3, 2,   50, 0, 0, 6};
    vecs[5] = '{1'b1,  5, 10, 2, 2,  700, 1, 2, 4};
    vecs[6] = '{1'b1,  1,  1, 4, 2, 8190, 1, 1, 8};
    vecs[7] = '{1'b1, 23, 11, 1, 1,   42, 1, 1, 1};
    vecs[8] = '{1'b1,  0,  0, 1, 3,  900, 4, 1, 12};
    vecs[9] = '{1'b1,  2,  2, 2, 1,  300, 1, 1, key_hits};

    rst = 1'b1; frame_start = 1'b0; bus.pix_valid = 1'b0; bus.col = '0; bus.row = '0;
    apply_cfg(vecs[0]);
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_hit", {31'd0, bus.out_hit}, 32'd0);
    check("rst_out_data", {20'd0, bus.out_data}, 32'd0);
    check("rst_mem_addr", {19'd0, bus.mem_addr}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // No frame_start yet: shadow enable is clear, so nothing hits.
    lat = vecs[2];
    scan(0, -1, vecs[0]);
    drain("pre_frame", 0);

    for (int v = 0; v < 10; v++) begin
      start_frame(vecs[v]);
      scan(0, -1, vecs[v]);
      drain($sformatf("vec%0d", v), vecs[v].exp_hits);
    end

    // Position change mid-frame only applies from the next frame.
    va = '{1'b1, 4, 2, 3, 2, 400, 2, 1, 12};
    vb = '{1'b1, 12, 6, 3, 2, 400, 2, 1, 12};
    start_frame(va);
    scan(0, 30, vb);
    drain("midframe_old", 12);
    start_frame(vb);
    scan(0, -1, vb);
    drain("midframe_new", 12);

    // Reset in the middle of an active line.
    va = '{1'b1, 0, 0, 8, 4, 500, 1, 1, 32};
    start_frame(va);
    for (int c = 0; c < 4; c++) pix(c, 0);
    @(negedge clk);
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    sbq.delete();
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_out_hit", {31'd0, bus.out_hit}, 32'd0);
    check("midrst_out_data", {20'd0, bus.out_data}, 32'd0);
    check("midrst_mem_addr", {19'd0, bus.mem_addr}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    hit_cnt = 0;
    lat.en = 1'b0;
    scan(4, -1, va);
    drain("after_rst", 0);
    start_frame(vecs[0]);
    scan(0, -1, vecs[0]);
    drain("recover", 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
